multiple_add_serializer: RTL and testbench
==========================================

Name: multiple_add_serializer

Overview:
- Sits directly downstream of the multiple_add pipeline.
- Captures the NUM_ADDERS-wide parallel sum array whenever the upstream valid pulses, then emits the elements one per beat, index 0 first, on a valid/ready stream.
- Upstream has no backpressure, so a one-deep pending buffer absorbs a second array while the first is draining. Anything beyond that is dropped and flagged.
- Follows the minimal-reset policy: only control state is reset; data registers are not.

Parameters:
- DATA_WIDTH, 32, width of each sum element.
- NUM_ADDERS, 64, elements per captured array; must be >= 2.
- IDX_WIDTH, $clog2(NUM_ADDERS), width of out_index (derived; do not override).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_data  input  DATA_WIDTH x NUM_ADDERS (unpacked array)  parallel sums from upstream out.
- in_valid  input  1  upstream valid_out; one-cycle pulse per array, may be back-to-back.
- out_data  output  DATA_WIDTH  current serialized element.
- out_index  output  IDX_WIDTH  index of out_data within its array.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_last  output  1  high with the element at index NUM_ADDERS-1.
- out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.
- busy  output  1  active buffer or pending buffer occupied.
- overflow  output  1  sticky; an input array was dropped.

Behaviour:
- Reset values: out_valid=0, out_index=0, out_last=0, busy=0, overflow=0, state=IDLE, pending_full=0.
- Reset does not clear active_buf, pending_buf or out_data contents; out_data is don't-care while out_valid=0.
- Reset asserted mid-drain aborts immediately. Partial and pending arrays are discarded; no further beats are emitted.
- FSM has two states: IDLE and SEND.
- IDLE + in_valid:
  - in_data loads active_buf, index=0, go to SEND.
  - out_valid=1 on the next cycle (latency 1).
- SEND behaviour:
  - out_valid=1; out_data=active_buf[out_index]; out_last=(out_index==NUM_ADDERS-1).
  - Beat transfers on out_valid&&out_ready.
  - Non-last transfer: out_index+1.
  - While out_ready=0, out_data/out_index/out_last hold stable.
- Last-beat transfer (out_last&&out_ready), resolved by priority:
  - pending_full=1: pending_buf moves to active_buf, index=0, stay in SEND (no bubble). If in_valid in the same cycle, in_data loads pending_buf (pending stays full, no drop).
  - pending_full=0 and in_valid: in_data loads active_buf directly, index=0, stay in SEND.
  - Otherwise: go to IDLE; out_valid=0 the next cycle.
- in_valid in SEND, not on a last-beat transfer:
  - pending_full=0: load pending_buf, set pending_full.
  - pending_full=1: drop in_data, set overflow. overflow clears only on reset.
- busy = (state==SEND) || pending_full.
- out_data is a registered read or mux of active_buf by out_index; no arithmetic on data.
- No wrap of out_index past NUM_ADDERS-1; it always returns to 0 on a new array.

Optional Feature:
- MULTIPLE_ADD_SERIALIZER_PENDING_EN
  - Defined: pending buffer present, behaving as above.
  - Undefined: no pending_buf.
    - in_valid in SEND not coinciding with a last-beat transfer is dropped and sets overflow.
    - The last-beat + in_valid direct reload into active_buf still applies.
    - busy = (state==SEND).

Test Plan (DATA_WIDTH=8, NUM_ADDERS=4):
- Reset, then in_valid pulse with in_data={10,11,12,13}, out_ready=1 -> beats 10,11,12,13 on cycles t+1..t+4, out_index 0..3, out_last only on 13, out_valid=0 at t+5, overflow=0.
- Same array with out_ready toggling 1,0,0,1,... -> each beat held stable while out_ready=0; all 4 delivered in order; no duplicates.
- PENDING_EN defined: arrays A={1,2,3,4} at t and B={5,6,7,8} at t+1, out_ready=1 -> 8 consecutive beats 1..8 with no bubble; out_last on 4 and 8; busy drops after 8.
- PENDING_EN defined: arrays A, B and C on three consecutive cycles, out_ready=1 -> A and B delivered; C dropped; overflow=1 from t+3 and held until rst=0.
- PENDING_EN undefined: arrays A at t and B at t+1 -> only A delivered; overflow=1. Array B presented on A's last-beat cycle -> A then B, no gap, overflow=0.
- rst driven low during beat 2 of A with B pending -> out_valid, busy and overflow go 0 asynchronously. After release, no beats until a new in_valid; the new array starts at index 0.

Source files
------------

// File: rtl/multiple_add_serializer_if.sv
// multiple_add_serializer_if: parallel-sum capture and serialized valid/ready stream
interface multiple_add_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ADDERS = 64
);
  localparam int IDX_WIDTH = $clog2(NUM_ADDERS);
  logic [DATA_WIDTH-1:0] in_data [NUM_ADDERS];
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]  out_index;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;
  logic                  busy;
  logic                  overflow;
  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_index, out_valid, out_last, busy, overflow
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_index, out_valid, out_last, busy, overflow
  );
endinterface

// File: rtl/multiple_add_serializer.sv
// multiple_add_serializer: captures parallel sum arrays and emits them one element per beat; MULTIPLE_ADD_SERIALIZER_PENDING_EN adds a one-deep pending buffer
module multiple_add_serializer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_ADDERS = 64,
  localparam int IDX_WIDTH  = $clog2(NUM_ADDERS)
) (
  input logic clk,
  input logic rst,
  multiple_add_serializer_if.slave s
);
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_ADDERS - 1);
  state_t                state;
  logic [IDX_WIDTH-1:0]  idx;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] active_buf [NUM_ADDERS];
  logic                  pending_full;
  logic                  xfer;
  logic                  last_xfer;
  logic                  start;
  logic                  load_active;
  logic                  drop;
  assign xfer        = state == SEND && s.out_ready;
  assign last_xfer   = xfer && idx == LAST;
  assign start       = s.in_valid && state == IDLE;
  assign load_active = s.in_valid && (state == IDLE || (last_xfer && !pending_full));
`ifdef MULTIPLE_ADD_SERIALIZER_PENDING_EN
  logic [DATA_WIDTH-1:0] pending_buf [NUM_ADDERS];
  logic                  load_pend;
  // On a last beat a full pending slot hands over and may refill in the same cycle
  assign load_pend = s.in_valid && state == SEND && (last_xfer ? pending_full : !pending_full);
  assign drop      = s.in_valid && state == SEND && !last_xfer && pending_full;
  // Pending data is not reset; pending_full alone qualifies it
  always_ff @(posedge clk)
    if (load_pend) pending_buf <= s.in_data;
  // Pending occupancy survives a last beat only when a new array arrives with it
  always_ff @(posedge clk or negedge rst)
    if (!rst) pending_full <= 1'b0;
    else if (last_xfer) pending_full <= pending_full && s.in_valid;
    else if (load_pend) pending_full <= 1'b1;
  // Active array reload: fresh input when nothing waits, else promote pending
  always_ff @(posedge clk)
    if (load_active) active_buf <= s.in_data;
    else if (last_xfer && pending_full) active_buf <= pending_buf;
`else
  assign pending_full = 1'b0;
  assign drop         = s.in_valid && state == SEND && !last_xfer;
  // Active array reload from the upstream sums
  always_ff @(posedge clk)
    if (load_active) active_buf <= s.in_data;
`endif
  // Control FSM: element index, IDLE/SEND and sticky overflow
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (start) state <= SEND;
      else if (last_xfer && !pending_full && !s.in_valid) state <= IDLE;
      idx <= (start || last_xfer) ? '0 : xfer ? idx + 1'b1 : idx;
      ovf <= ovf || drop;
    end
  assign s.out_valid = state == SEND;
  assign s.out_index = idx;
  assign s.out_last  = state == SEND && idx == LAST;
  assign s.out_data  = active_buf[idx];
  assign s.busy      = state == SEND || pending_full;
  assign s.overflow  = ovf;
endmodule

// File: tb/tb_multiple_add_serializer.sv
// tb_multiple_add_serializer: scoreboard bench for the serializer with 4 x 8-bit arrays
module tb_multiple_add_serializer;
`ifdef MULTIPLE_ADD_SERIALIZER_PENDING_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  int gaps = 0;
  logic [10:0] q [$];
  logic held = 1'b0;
  logic [10:0] held_v;
  multiple_add_serializer_if #(.DATA_WIDTH(8), .NUM_ADDERS(4)) s();
  multiple_add_serializer #(.DATA_WIDTH(8), .NUM_ADDERS(4)) dut (.clk(clk), .rst(rst), .s(s));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // beats are checked mid-cycle against the expected queue; stalled beats must hold
  always @(negedge clk)
    if (rst) begin
      if (held) chk("stall_hold", {s.out_data, s.out_index, s.out_last}, held_v);
      if (s.out_valid && s.out_ready) begin
        chk("unexpected_beat", q.size() != 0, 1);
        if (q.size() != 0) chk("beat", {s.out_data, s.out_index, s.out_last}, q.pop_front());
      end else if (q.size() != 0 && !s.out_valid) gaps++;
      held = s.out_valid && !s.out_ready;
      held_v = {s.out_data, s.out_index, s.out_last};
    end else held = 1'b0;
  task automatic send(input logic [7:0] b, input bit exp);
    s.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) s.in_data[i] = b + 8'(i);
    @(posedge clk); #1;
    s.in_valid = 1'b0;
    if (exp) for (int i = 0; i < 4; i++) q.push_back({b + 8'(i), 2'(i), i == 3});
  endtask
  task automatic drain(input logic [3:0] pat);
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      s.out_ready = pat[k % 4];
      @(posedge clk); #1;
      k++;
    end
    s.out_ready = 1'b1;
    chk("drain_done", q.size(), 0);
  endtask
  task automatic pulse_rst();
    rst = 1'b0;
    #1;
    chk("rst_ovf", s.overflow, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    rst = 1'b0;
    s.in_valid = 1'b0;
    s.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) s.in_data[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", s.out_valid, 0);
    chk("rst_index", s.out_index, 0);
    chk("rst_last", s.out_last, 0);
    chk("rst_busy", s.busy, 0);
    chk("rst_ovf", s.overflow, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    send(8'd10, 1'b1);
    chk("t1_lat_valid", s.out_valid, 1);
    chk("t1_lat_index", s.out_index, 0);
    chk("t1_lat_data", s.out_data, 10);
    drain(4'b1111);
    chk("t1_end_valid", s.out_valid, 0);
    chk("t1_end_busy", s.busy, 0);
    chk("t1_end_ovf", s.overflow, 0);
    chk("t1_gaps", gaps, 0);
    send(8'd10, 1'b1);
    drain(4'b1001);
    chk("t2_end_valid", s.out_valid, 0);
    chk("t2_gaps", gaps, 0);
    send(8'd1, 1'b1);
    send(8'd5, PEN);
    chk("t3_busy", s.busy, 1);
    drain(4'b1111);
    chk("t3_gaps", gaps, 0);
    chk("t3_end_busy", s.busy, 0);
    chk("t3_ovf", s.overflow, !PEN);
    pulse_rst();
    send(8'd1, 1'b1);
    send(8'd5, PEN);
    send(8'd9, 1'b0);
    chk("t4_ovf_set", s.overflow, 1);
    drain(4'b1111);
    chk("t4_ovf_held", s.overflow, 1);
    chk("t4_end_busy", s.busy, 0);
    chk("t4_gaps", gaps, 0);
    pulse_rst();
    send(8'd10, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t5_last_before_reload", s.out_last, 1);
    send(8'd20, 1'b1);
    drain(4'b1111);
    chk("t5_gaps", gaps, 0);
    chk("t5_ovf", s.overflow, 0);
    chk("t5_end_valid", s.out_valid, 0);
    send(8'd1, 1'b1);
    send(8'd5, PEN);
    send(8'd9, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", s.out_valid, 0);
    chk("t6_rst_busy", s.busy, 0);
    chk("t6_rst_ovf", s.overflow, 0);
    chk("t6_rst_index", s.out_index, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_idle_valid", s.out_valid, 0);
    chk("t6_idle_busy", s.busy, 0);
    send(8'd30, 1'b1);
    chk("t6_new_index", s.out_index, 0);
    chk("t6_new_data", s.out_data, 30);
    drain(4'b1111);
    chk("t6_gaps", gaps, 0);
    chk("t6_end_valid", s.out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
